// File: rtl/fifo_refill_unit_if.sv
// Memory read port and FIFO push port of the refill unit, grouped as one bundle.
// master: the refill unit; slave: the memory/FIFO side.
interface fifo_refill_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  push_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  full_i;

  modport master (
    output mem_req_o, mem_addr_o, push_o, data_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, full_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, push_o, data_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, full_i
  );
endinterface

// File: rtl/fifo_refill_unit.sv
// Fetches one cache line over a single-outstanding req/gnt/rvalid port and pushes it into a FIFO.
// Optional macro FIFO_REFILL_WRAP_FIRST_EN: critical-word-first ordering within the line.
module fifo_refill_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  fifo_refill_unit_if.master    bus
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BYTE_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = $clog2(BURST_LEN);
  localparam int unsigned OFF_W  = $clog2(BURST_LEN * BYTES);
  localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q,  base_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  done_q,  done_d;
  logic                  req_c;
  logic                  push_c;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; flush outranks grant and rvalid in every busy state
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    req_c   = 1'b0;
    push_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d  = addr_i & ~OFF_MASK;
`ifdef FIFO_REFILL_WRAP_FIRST_EN
          idx_d   = addr_i[OFF_W-1:BYTE_W];
`else
          idx_d   = '0;
`endif
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // Holding the request while full guarantees every returned word has a slot
        req_c = !bus.full_i;
        if (flush_i) begin
          state_d = (req_c && bus.mem_gnt_i) ? ST_DRAIN : ST_IDLE;
        end else if (req_c && bus.mem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.mem_rvalid_i) begin
          if (flush_i) begin
            state_d = ST_IDLE;
          end else begin
            push_c = 1'b1;
            idx_d  = idx_q + IDX_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_REQ;
            end
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (bus.mem_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_req_o  = req_c;
  assign bus.mem_addr_o = base_q + (ADDR_WIDTH'(idx_q) << BYTE_W);
  assign bus.push_o     = push_c;
  assign bus.data_o     = bus.mem_rdata_i;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;

endmodule

// File: tb/tb_fifo_refill_unit.sv
// Directed bench for fifo_refill_unit: bench-side memory responder plus address/data scoreboard.
module tb_fifo_refill_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk_i;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] addr_i;
  logic          flush_i;
  logic          busy_o;
  logic          done_o;

  int checks;
  int passes;
  int fails;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  fifo_refill_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_refill_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .addr_i  (addr_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; returns at the falling edge where inputs are driven
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Push expected line order and data to the scoreboard, then pulse start_i
  task automatic start_line(input logic [AW-1:0] a, input logic [DW-1:0] dbase);
    int first;
`ifdef FIFO_REFILL_WRAP_FIRST_EN
    first = int'((a >> 2) & 32'd3);
`else
    first = 0;
`endif
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back((a & ~32'hF) + AW'(((first + k) % 4) * 4));
      exp_data_q.push_back(dbase + DW'(k));
    end
    start_i = 1'b1;
    addr_i  = a;
    tick();
    start_i = 1'b0;
  endtask

  // Act as memory for nwords words; on a full line also check the done pulse
  task automatic serve(input int nwords);
    logic [DW-1:0] d;
    for (int k = 0; k < nwords; k++) begin
      int waited;
      waited = 0;
      #1;
      while (!bus.mem_req_o && waited < 20) begin
        tick();
        #1;
        waited++;
      end
      check("req_seen", 64'(bus.mem_req_o), 64'd1);
      check("mem_addr", 64'(bus.mem_addr_o), 64'(exp_addr_q.pop_front()));
      bus.mem_gnt_i = 1'b1;
      tick();
      bus.mem_gnt_i = 1'b0;
      d = exp_data_q.pop_front();
      check("req_low_wait", 64'(bus.mem_req_o), 64'd0);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = d;
      #1;
      check("push", 64'(bus.push_o), 64'd1);
      check("push_data", 64'(bus.data_o), 64'(d));
      tick();
      bus.mem_rvalid_i = 1'b0;
    end
    if (nwords == 4) begin
      #1;
      check("done_pulse", 64'(done_o), 64'd1);
      check("busy_after", 64'(busy_o), 64'd0);
      tick();
      #1;
      check("done_one_cycle", 64'(done_o), 64'd0);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    rst_ni = 1'b1;
    start_i = 1'b0;
    addr_i  = '0;
    flush_i = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.full_i       = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #2 rst_ni = 1'b0;
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_req", 64'(bus.mem_req_o), 64'd0);
    check("rst_push", 64'(bus.push_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Aligned burst
    start_line(32'h100, 32'hA0);
    check("busy_in_req", 64'(busy_o), 64'd1);
    serve(4);

    // Backpressure: request held low while full, rises combinationally when it drops
    bus.full_i = 1'b1;
    start_line(32'h300, 32'hC0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_req_low", 64'(bus.mem_req_o), 64'd0);
      check("bp_addr_stable", 64'(bus.mem_addr_o), 64'h300);
      tick();
    end
    bus.full_i = 1'b0;
    #1;
    check("bp_req_rise", 64'(bus.mem_req_o), 64'd1);
    check("bp_addr", 64'(bus.mem_addr_o), 64'h300);
    serve(4);

    // Flush in REQ without grant goes straight back to idle
    start_line(32'h600, 32'h60);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("flush_req_idle", 64'(busy_o), 64'd0);
    tick();

    // Flush in WAIT two cycles ahead of rvalid: word dropped, no done
    start_line(32'h400, 32'hD0);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("drain_busy", 64'(busy_o), 64'd1);
    tick();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD;
    #1;
    check("drain_no_push", 64'(bus.push_o), 64'd0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    #1;
    check("drain_idle", 64'(busy_o), 64'd0);
    check("drain_no_done", 64'(done_o), 64'd0);
    tick();
    #1;
    check("drain_no_done2", 64'(done_o), 64'd0);

    // Normal fetch after the abort
    start_line(32'h500, 32'hE0);
    serve(4);

    // Unaligned start address: order depends on critical-word-first build
    start_line(32'h108, 32'hB0);
    serve(4);

    // Reset after the second push, then a stray rvalid, then a clean refetch
    start_line(32'h700, 32'hF0);
    serve(2);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_req", 64'(bus.mem_req_o), 64'd0);
    check("mid_rst_push", 64'(bus.push_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBAD;
    #1;
    check("stray_no_push", 64'(bus.push_o), 64'd0);
    check("stray_idle", 64'(busy_o), 64'd0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    start_line(32'h200, 32'h20);
    serve(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_refill_unit.md
Name: fifo_refill_unit

Overview:
- Upstream feeder for the instruction/data FIFO (ucsbece154b_fifo).
- On a start command, fetches one cache line of BURST_LEN words from memory over a single-outstanding req/gnt/rvalid interface.
- Pushes each returned word into the FIFO.
- Never issues a memory request while the FIFO reports full, so no returned word is ever dropped.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- BURST_LEN, 4, words per line; power of two, >= 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start a line fetch; accepted only in IDLE.
- addr_i  in  ADDR_WIDTH  byte address of the requested word; sampled with start_i.
- flush_i  in  1  abort the current fetch.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse after the last word of a completed line is pushed.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  ADDR_WIDTH  request byte address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; arrives >= 1 cycle after its grant.
- mem_rdata_i  in  DATA_WIDTH  read data.
- push_o  out  1  FIFO push strobe (to push_i).
- data_o  out  DATA_WIDTH  FIFO write data (to data_i).
- full_i  in  1  FIFO full (from full_o).

Behaviour:
- Reset (async, rst_ni=0): state IDLE, word counter 0, base/index registers 0, done_o 0. Combinational outputs then evaluate to mem_req_o=0, push_o=0, busy_o=0.
- Address math: BYTES = DATA_WIDTH/8. base = addr_i with the low log2(BURST_LEN*BYTES) bits cleared. idx is a log2(BURST_LEN)-bit index that wraps modulo BURST_LEN. mem_addr_o = base + idx*BYTES; it never leaves the line.
- State IDLE: start_i=1 latches base and start idx, clears the counter, goes to REQ. flush_i in IDLE has no effect.
- State REQ: mem_req_o = !full_i (combinational).
  - mem_addr_o is held stable until granted.
  - Request granted (mem_req_o & mem_gnt_i) -> WAIT.
  - full_i cannot rise while in REQ, because only this block pushes, so a raised request never drops.
- State WAIT: mem_req_o=0. On mem_rvalid_i:
  - push_o=1 and data_o=mem_rdata_i in the same cycle (combinational pass-through; zero added latency).
  - idx and counter increment.
  - If the counter reaches BURST_LEN -> IDLE and done_o=1 next cycle. Otherwise -> REQ.
  - The FIFO's updated full_o is therefore visible in the next REQ cycle.
- State DRAIN (abort with a response in flight): push_o forced 0. On mem_rvalid_i the word is discarded -> IDLE.
- Flush rules (flush_i has priority over everything except reset):
  - REQ, no grant this cycle -> IDLE.
  - REQ with grant in the same cycle -> DRAIN.
  - WAIT without rvalid -> DRAIN.
  - WAIT with rvalid in the same cycle -> word discarded (push_o=0), -> IDLE.
  - DRAIN -> stays DRAIN until rvalid.
  - An aborted fetch never pulses done_o.
- start_i outside IDLE is ignored; the caller must wait for busy_o=0.
- done_o is registered and high exactly one cycle. start_i in that cycle is accepted, since state is already IDLE.
- Reset mid-burst: immediate return to IDLE, all outputs low. A late rvalid arriving after reset is ignored in IDLE.
- Fetch timing: one request outstanding at a time. Best case is 2 cycles per word (grant in cycle 0, rvalid in cycle 1).

Optional Feature:
- Macro: FIFO_REFILL_WRAP_FIRST_EN.
- Defined: critical-word-first. Start idx = word index of addr_i within the line; the sequence wraps (e.g. idx 2,3,0,1).
- Undefined: start idx = 0 and the addr_i word offset is ignored (sequence 0,1,2,3). Ports are identical in both builds.

Test Plan:
- Reset: rst_ni=0 mid-cycle with no clock edge -> busy_o=0, mem_req_o=0, push_o=0, done_o=0 immediately.
- Aligned burst, BURST_LEN=4, addr_i=0x100, gnt same cycle as req, rvalid 1 cycle later with data 0xA0..0xA3 -> mem_addr_o 0x100,0x104,0x108,0x10C; four push_o pulses carrying 0xA0..0xA3; done_o high one cycle after the 4th push; busy_o then 0.
- Backpressure: full_i=1 on entry to REQ for 5 cycles -> mem_req_o=0 throughout; full_i drops -> mem_req_o=1 the same cycle, same mem_addr_o.
- Flush in WAIT: flush_i=1 two cycles before rvalid -> state DRAIN; the rvalid word is not pushed (push_o=0); then IDLE; no done_o pulse. A subsequent start_i works normally.
- Wrap: addr_i=0x108. With FIFO_REFILL_WRAP_FIRST_EN -> addresses 0x108,0x10C,0x100,0x104. Without -> 0x100,0x104,0x108,0x10C.
- Reset mid-burst after the 2nd push -> IDLE at once; a stray rvalid next cycle produces no push_o; a new start_i with addr_i=0x200 fetches the full line from 0x200.
